// File: rtl/aap_fetch_pkg.sv
// -----------------------------------------------------------------------------
// aap_fetch_pkg
//
// Shared definitions for the AAP instruction fetch stage:
//   - fetch FSM state encoding (2 bits)
//   - instruction address / word / assembled-instruction widths
//   - index of the length bit inside the first instruction word
//   - default reset PC
//   - PC sequencing helper (modulo 2^24)
// -----------------------------------------------------------------------------
package aap_fetch_pkg;

    localparam int IADDR_W = 24;   // instruction word address width
    localparam int IWORD_W = 16;   // instruction memory word width
    localparam int INSTR_W = 32;   // assembled instruction width
    localparam int LEN_BIT = 15;   // set in the first word => 32-bit instruction

    localparam logic [IADDR_W-1:0] RESET_PC_DEFAULT = 24'h000000;

    typedef enum logic [1:0] {
        REQ_HI  = 2'd0,  // request first word at pc
        DATA_HI = 2'd1,  // first word returning, speculative read of pc+1
        DATA_LO = 2'd2,  // second word of a 32-bit instruction returning
        HOLD    = 2'd3   // instruction presented, waiting for execute
    } fetch_state_e;

    // Address of the instruction following the one at 'pc'. The sum is
    // truncated to IADDR_W bits, so it wraps from 24'hFFFFFF to 24'h000000.
    function automatic logic [IADDR_W-1:0] pc_step(input logic [IADDR_W-1:0] pc,
                                                   input logic               len32);
        return pc + (len32 ? 24'd2 : 24'd1);
    endfunction

endpackage

// File: rtl/aap_fetch_if.sv
// -----------------------------------------------------------------------------
// aap_fetch_if
//
// Bundles the fetch stage's two buses:
//   instruction memory : i_raddr, i_re (fetch -> mem), i_rdata (mem -> fetch)
//   execute interface  : instr, instr_pc, instr_len32, instr_valid
//                        (fetch -> execute), instr_ready, redirect_valid,
//                        redirect_pc (execute -> fetch)
//
// Modports:
//   master : the fetch stage itself
//   slave  : the environment (instruction memory + execute stage)
// -----------------------------------------------------------------------------
interface aap_fetch_if;
    import aap_fetch_pkg::*;

    // instruction memory bus
    logic [IADDR_W-1:0] i_raddr;
    logic               i_re;
    logic [IWORD_W-1:0] i_rdata;

    // fetch -> execute
    logic [INSTR_W-1:0] instr;
    logic [IADDR_W-1:0] instr_pc;
    logic               instr_len32;
    logic               instr_valid;
    logic               instr_ready;

    // execute -> fetch control flow
    logic               redirect_valid;
    logic [IADDR_W-1:0] redirect_pc;

    modport master (
        output i_raddr, i_re,
        input  i_rdata,
        output instr, instr_pc, instr_len32, instr_valid,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  i_raddr, i_re,
        output i_rdata,
        input  instr, instr_pc, instr_len32, instr_valid,
        output instr_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/aap_fetch.sv
// -----------------------------------------------------------------------------
// aap_fetch
//
// Instruction fetch stage feeding the execute stage. Reads 16-bit words from
// instruction memory (one-cycle read latency) and assembles 16-bit or 32-bit
// instructions; bit 15 of the first word set means a 32-bit instruction.
// Each instruction is presented with its PC over a valid/ready handshake.
// A redirect from execute reloads the PC and drops anything in flight.
//
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : synchronous active-high reset
//   fb   : aap_fetch_if.master
//          i_raddr/i_re/i_rdata          instruction memory read port
//          instr/instr_pc/instr_len32    assembled instruction + its PC
//          instr_valid/instr_ready       handshake with execute
//          redirect_valid/redirect_pc    PC reload from execute
//
// Parameters:
//   RESET_PC : PC loaded on reset
//
// Build option:
//   AAP_FETCH_PREFETCH_EN : while an instruction waits in HOLD, keep reading
//                           the first word of the next sequential
//                           instruction so a handshake can go straight to
//                           DATA_HI (one cycle saved per instruction).
// -----------------------------------------------------------------------------
module aap_fetch
    import aap_fetch_pkg::*;
#(
    parameter logic [IADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    aap_fetch_if.master  fb
);

    fetch_state_e       state;
    fetch_state_e       state_nxt;
    logic [IADDR_W-1:0] pc;
    logic [IADDR_W-1:0] pc_nxt;
    logic [IADDR_W-1:0] pc_seq;

    logic [INSTR_W-1:0] instr_q;
    logic [IADDR_W-1:0] instr_pc_q;
    logic               len32_q;
    logic               valid_q;

    logic               re;
    logic [IADDR_W-1:0] raddr;
    logic               handshake;
    logic               first_is_32;

    // valid_q is only ever set while in HOLD, so it alone qualifies the
    // handshake; instr_ready with no valid instruction does nothing.
    assign handshake   = valid_q & fb.instr_ready;
    assign pc_seq      = pc_step(pc, len32_q);
    assign first_is_32 = fb.i_rdata[LEN_BIT];

    // ---------------------------------------------------------------------
    // Next-state, next-PC and memory request decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        re        = 1'b0;
        raddr     = pc;

        case (state)
            REQ_HI: begin
                re        = 1'b1;
                raddr     = pc;
                state_nxt = DATA_HI;
            end

            DATA_HI: begin
                // The second-word read goes out regardless of the length
                // bit so the address never depends on returning data; for a
                // 16-bit instruction its result is simply not used.
                re        = 1'b1;
                raddr     = pc + 24'd1;
                state_nxt = first_is_32 ? DATA_LO : HOLD;
            end

            DATA_LO: begin
                state_nxt = HOLD;
            end

            HOLD: begin
`ifdef AAP_FETCH_PREFETCH_EN
                // Reissued every cycle: only the read in the handshake
                // cycle matters, and its data lands in DATA_HI.
                re    = 1'b1;
                raddr = pc_seq;
                if (handshake) begin
                    pc_nxt    = pc_seq;
                    state_nxt = DATA_HI;
                end
`else
                if (handshake) begin
                    pc_nxt    = pc_seq;
                    state_nxt = REQ_HI;
                end
`endif
            end

            default: begin
                state_nxt = REQ_HI;
            end
        endcase

        // Redirect overrides everything, including a same-cycle handshake:
        // the presented instruction still counts as consumed, but the
        // sequential PC is replaced by the target.
        if (fb.redirect_valid) begin
            pc_nxt    = fb.redirect_pc;
            state_nxt = REQ_HI;
        end
    end

    assign fb.i_re    = re & ~rst;
    assign fb.i_raddr = raddr;

    // ---------------------------------------------------------------------
    // State, PC and instruction registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ_HI;
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
            len32_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            // Registered from the next state so instr_valid is glitch-free
            // and drops the cycle after a redirect.
            valid_q <= (state_nxt == HOLD);

            // Data returning after a redirect belongs to a stale request.
            if (!fb.redirect_valid) begin
                case (state)
                    DATA_HI: begin
                        instr_q[INSTR_W-1:IWORD_W] <= fb.i_rdata;
                        instr_pc_q                 <= pc;
                        len32_q                    <= first_is_32;
                        if (!first_is_32) begin
                            instr_q[IWORD_W-1:0] <= '0;
                        end
                    end
                    DATA_LO: begin
                        instr_q[IWORD_W-1:0] <= fb.i_rdata;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign fb.instr       = instr_q;
    assign fb.instr_pc    = instr_pc_q;
    assign fb.instr_len32 = len32_q;
    assign fb.instr_valid = valid_q;

endmodule

// File: tb/tb_aap_fetch.sv
// -----------------------------------------------------------------------------
// tb_aap_fetch
//
// Drives aap_fetch against a 1024-word instruction memory (addresses alias
// modulo 1024) and compares every cycle with a reference model that tracks
// only the architectural PC and the cycle at which the next instruction is
// due, both derived from the fetch-timing rules. Directed scenarios first,
// then randomized ready / redirect / reset traffic.
// Build option mirrored from the design: AAP_FETCH_PREFETCH_EN.
// -----------------------------------------------------------------------------
module tb_aap_fetch;
    import aap_fetch_pkg::*;

`ifdef AAP_FETCH_PREFETCH_EN
    localparam int HS_BASE  = 1;  // handshake -> next first word already requested
    localparam bit PREFETCH = 1'b1;
`else
    localparam int HS_BASE  = 2;  // handshake -> REQ_HI -> DATA_HI
    localparam bit PREFETCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aap_fetch_if bus();

    aap_fetch #(.RESET_PC(24'h000000)) dut (
        .clk (clk),
        .rst (rst),
        .fb  (bus)
    );

    logic [15:0] mem [0:1023];

    always @(posedge clk) begin
        if (bus.i_re) bus.i_rdata <= mem[bus.i_raddr[9:0]];
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ready_at = 0;   // first cycle the next instruction must be valid
    logic [23:0] pc_m;           // architectural PC of the next instruction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [23:0] a);
        return mem[a[9:0]];
    endfunction

    function automatic int len_of(input logic [23:0] a);
        logic [15:0] w;
        w = mem_rd(a);
        return w[15] ? 2 : 1;
    endfunction

    function automatic logic [31:0] exp_instr(input logic [23:0] a);
        logic [15:0] w0;
        w0 = mem_rd(a);
        return w0[15] ? {w0, mem_rd(a + 24'd1)} : {w0, 16'h0000};
    endfunction

    // Check this cycle against the model, apply inputs, advance one clock.
    task automatic step(input logic rdy, input logic rv, input logic [23:0] rpc);
        logic        ev;
        logic [23:0] nxt;
        ev  = (cyc >= ready_at);
        nxt = pc_m + 24'(len_of(pc_m));
        check_val("instr_valid", bus.instr_valid, ev);
        if (ev) begin
            check_val("instr", bus.instr, exp_instr(pc_m));
            check_val("instr_pc", bus.instr_pc, pc_m);
            check_val("instr_len32", bus.instr_len32, len_of(pc_m) == 2);
            check_val("hold_i_re", bus.i_re, PREFETCH);
            if (PREFETCH) check_val("hold_i_raddr", bus.i_raddr, nxt);
        end
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        if (ev && rdy) begin
            pc_m     = nxt;
            ready_at = cyc + HS_BASE + len_of(pc_m);
        end
        if (rv) begin
            pc_m     = rpc;
            ready_at = cyc + 2 + len_of(pc_m);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to_valid(input logic rdy);
        int guard;
        guard = 0;
        while (cyc < ready_at && guard < 12) begin
            step(rdy, 1'b0, 24'h0);
            guard++;
        end
    endtask

    // Two reset cycles with ready and a redirect asserted (both must be
    // ignored), then release and check the first request.
    task automatic do_reset();
        rst                = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 24'h000321;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            check_val("rst_i_re", bus.i_re, 1'b0);
            check_val("rst_valid", bus.instr_valid, 1'b0);
        end
        check_val("rst_instr", bus.instr, 32'h0);
        check_val("rst_instr_pc", bus.instr_pc, 24'h0);
        check_val("rst_len32", bus.instr_len32, 1'b0);
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        check_val("post_rst_i_re", bus.i_re, 1'b1);
        check_val("post_rst_i_raddr", bus.i_raddr, 24'h000000);
        pc_m     = 24'h000000;
        ready_at = cyc + 1 + len_of(pc_m);
    endtask

    initial begin
        int          t_prev;
        logic [23:0] rpc;

        rst                = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 24'h0;

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[0]     = 16'h1234;
        mem[1]     = 16'h0042;
        mem[4]     = 16'h8A01;
        mem[5]     = 16'h5678;
        mem[6]     = 16'h0007;
        mem[256]   = 16'h0ABC;
        mem[1023]  = 16'h8001;
        for (int i = 512; i < 528; i++) mem[i] = 16'(i) & 16'h7FFF;

        // reset, first 16-bit instruction at 0
        do_reset();
        run_to_valid(1'b1);
        check_val("t1_instr", bus.instr, 32'h12340000);
        step(1'b1, 1'b0, 24'h0);
        check_val("t1_next_raddr", bus.i_raddr, PREFETCH ? 24'h000002 : 24'h000001);

        // 32-bit instruction at 4
        step(1'b0, 1'b1, 24'h000004);
        run_to_valid(1'b1);
        check_val("t2_instr", bus.instr, 32'h8A015678);
        check_val("t2_len32", bus.instr_len32, 1'b1);
        step(1'b1, 1'b0, 24'h0);
        check_val("t2_next_raddr", bus.i_raddr, PREFETCH ? 24'h000007 : 24'h000006);

        // stall in HOLD for 5 cycles, then exactly one handshake
        step(1'b0, 1'b1, 24'h000004);
        run_to_valid(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b0, 24'h0);
        check_val("t3_single_hs", bus.instr_valid, 1'b0);
        step(1'b0, 1'b0, 24'h0);

        // redirect during DATA_LO of the instruction at 4
        step(1'b0, 1'b1, 24'h000004);
        step(1'b1, 1'b0, 24'h0);
        step(1'b1, 1'b0, 24'h0);
        step(1'b1, 1'b1, 24'h000100);
        check_val("t4_raddr", bus.i_raddr, 24'h000100);
        check_val("t4_re", bus.i_re, 1'b1);
        run_to_valid(1'b0);
        check_val("t4_instr_pc", bus.instr_pc, 24'h000100);
        step(1'b1, 1'b0, 24'h0);

        // 32-bit instruction straddling the top of the address space
        step(1'b0, 1'b1, 24'hFFFFFF);
        run_to_valid(1'b0);
        check_val("t5_instr", bus.instr, 32'h80011234);
        step(1'b1, 1'b0, 24'h0);
        run_to_valid(1'b0);
        check_val("t5_next_pc", bus.instr_pc, 24'h000001);
        step(1'b1, 1'b0, 24'h0);

        // streaming 16-bit instructions with ready held high
        step(1'b1, 1'b1, 24'h000200);
        run_to_valid(1'b1);
        t_prev = cyc;
        step(1'b1, 1'b0, 24'h0);
        for (int k = 0; k < 6; k++) begin
            run_to_valid(1'b1);
            check_val("t6_gap", cyc - t_prev, HS_BASE + 1);
            t_prev = cyc;
            step(1'b1, 1'b0, 24'h0);
        end
        // redirect in the same cycle as a handshake
        run_to_valid(1'b1);
        step(1'b1, 1'b1, 24'h000300);
        run_to_valid(1'b0);
        check_val("t6_redir_hs_pc", bus.instr_pc, 24'h000300);

        // reset in the middle of a fetch
        step(1'b0, 1'b1, 24'h000004);
        step(1'b1, 1'b0, 24'h0);
        do_reset();
        run_to_valid(1'b1);
        check_val("t7_instr_pc", bus.instr_pc, 24'h000000);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                rpc = ($urandom_range(0, 7) == 0) ? (24'hFFFFF0 + 24'($urandom_range(0, 15)))
                                                  : 24'($urandom_range(0, 1023));
                step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
